dma_request_agent: RTL and testbench



---
 rtl/dma_agent_pkg.sv | 18 +
 rtl/dma_request_agent_if.sv | 34 +++
 rtl/dma_request_agent_fifo.sv | 62 ++++++
 rtl/dma_request_agent.sv | 119 +++++++++++
 tb/tb_dma_request_agent.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_agent_pkg.sv
// Shared definitions for the DMA request agent.
// Contents:
//   agent_state_t            channel-service FSM state
//   DEF_DATA_W/DEPTH/THRESH  default geometry
package dma_agent_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } agent_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_THRESH = 4;

endpackage

// File: rtl/dma_request_agent_if.sv
// Bundle of the peripheral write port and the DREQ/DACK controller channel.
// Port summary (agent view, modport master):
//   in : wrData, wrValid, flush, demandMode, DACK, IOR_N, EOP_N
//   out: wrReady, DREQ, DB, DB_EN, fillLevel, eopSeen, underrun
// Modport slave is the environment's view (peripheral core + controller).
interface dma_request_agent_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) ();
    logic [DATA_W-1:0]          wrData;
    logic                       wrValid;
    logic                       wrReady;
    logic                       flush;
    logic                       demandMode;
    logic                       DREQ;
    logic                       DACK;
    logic                       IOR_N;
    logic                       EOP_N;
    logic [DATA_W-1:0]          DB;
    logic                       DB_EN;
    logic [$clog2(DEPTH):0]     fillLevel;
    logic                       eopSeen;
    logic                       underrun;

    modport master (
        input  wrData, wrValid, flush, demandMode, DACK, IOR_N, EOP_N,
        output wrReady, DREQ, DB, DB_EN, fillLevel, eopSeen, underrun
    );

    modport slave (
        output wrData, wrValid, flush, demandMode, DACK, IOR_N, EOP_N,
        input  wrReady, DREQ, DB, DB_EN, fillLevel, eopSeen, underrun
    );
endinterface

// File: rtl/dma_request_agent_fifo.sv
// sync_fifo: DEPTH x DATA_W show-ahead FIFO with occupancy count.
// Ports:
//   clk, rst_n       clock, async active-low reset (pointers/count only)
//   push, wr_data    write request (ignored when full)
//   pop              read request (ignored when empty)
//   head             word at the read pointer, valid while !empty
//   count            occupancy 0..DEPTH
//   full, empty      status flags derived from count
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dma_request_agent.sv
// dma_request_agent: peripheral-side end of one DREQ/DACK DMA channel.
// Buffers peripheral words, requests service at a fill threshold (or on
// flush), drives one word per controller read strobe and releases the
// channel on single-transfer completion, FIFO empty (demand mode) or EOP.
// Ports:
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   bus      dma_request_agent_if.master (write port, channel, status)
module dma_request_agent
    import dma_agent_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int THRESH = DEF_THRESH
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    dma_request_agent_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    agent_state_t       state;
    agent_state_t       state_next;
    logic               ior_n_p1;
    logic               strobe_end;
    logic               push;
    logic               pop;
    logic               eop_hit;
    logic               dreq_q;
    logic               eop_seen_q;
    logic               underrun_q;
    logic [DATA_W-1:0]  head;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push    (push),
        .wr_data (bus.wrData),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // A strobe completes on the rising edge of IOR_N while DACK is held.
    assign strobe_end = bus.DACK && !ior_n_p1 && bus.IOR_N;
    // The pop is independent of FSM state: a strobe that finishes after an
    // EOP-driven release still consumes its word.
    assign pop        = strobe_end && !empty;
    assign push       = bus.wrValid && !full;

    assign bus.wrReady   = !full;
    assign bus.fillLevel = count;
    assign bus.DB_EN     = bus.DACK && !bus.IOR_N;
    assign bus.DB        = (bus.DB_EN && !empty) ? head : '0;
    assign bus.DREQ      = dreq_q;
    assign bus.eopSeen   = eop_seen_q;
    assign bus.underrun  = underrun_q;

    // Stage p1: registered strobe, state and flag outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ior_n_p1   <= 1'b1;
            state      <= IDLE;
            dreq_q     <= 1'b0;
            eop_seen_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ior_n_p1   <= bus.IOR_N;
            state      <= state_next;
            dreq_q     <= (state_next == REQ) || (state_next == SERVE);
            eop_seen_q <= eop_hit;
            if (strobe_end && empty)
                underrun_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        eop_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (count >= THRESH_C || (bus.flush && count != '0))
                    state_next = REQ;
            end
            REQ: begin
                if (bus.DACK)
                    state_next = SERVE;
            end
            SERVE: begin
                // EOP wins over a same-cycle strobe end.
                if (bus.DACK && !bus.EOP_N) begin
                    state_next = RELEASE;
                    eop_hit    = 1'b1;
                end else if (!bus.DACK) begin
                    state_next = REQ;
                end else if (strobe_end) begin
                    if (!bus.demandMode)
                        state_next = RELEASE;
                    else if (pop && count == CW'(1) && !push)
                        state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.DACK)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dma_request_agent.sv
module tb_dma_request_agent;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    dma_request_agent_if #(.DATA_W(8), .DEPTH(8)) bus ();

    dma_request_agent #(
        .DATA_W (8),
        .DEPTH  (8),
        .THRESH (4)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.wrData  = d;
        bus.wrValid = 1'b1;
        tick();
        bus.wrValid = 1'b0;
    endtask

    // Two-cycle read strobe; expected bus word goes to the scoreboard.
    task automatic strobe(input logic [7:0] exp);
        sb.push_back(exp);
        bus.IOR_N = 1'b0;
        tick();
        tick();
        bus.IOR_N = 1'b1;
        tick();
    endtask

    task automatic wait_dreq(input string name, input logic exp);
        for (int i = 0; i < 20 && bus.DREQ !== exp; i++)
            tick();
        chk(name, int'(bus.DREQ), int'(exp));
    endtask

    task automatic apply_reset();
        bus.DACK    = 1'b0;
        bus.IOR_N   = 1'b1;
        bus.EOP_N   = 1'b1;
        bus.wrValid = 1'b0;
        bus.flush   = 1'b0;
        #2 RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    // Monitor: one bus word per rising DB_EN, compared against the scoreboard.
    initial begin
        logic       prev;
        logic [7:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET_N && bus.DB_EN && !prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL db_unexpected: got 0x%0h, expected no strobe", bus.DB);
                end else begin
                    exp = sb.pop_front();
                    chk("db_word", int'(bus.DB), int'(exp));
                end
            end
            prev = bus.DB_EN;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wrData     = '0;
        bus.wrValid    = 1'b0;
        bus.flush      = 1'b0;
        bus.demandMode = 1'b0;
        bus.DACK       = 1'b0;
        bus.IOR_N      = 1'b1;
        bus.EOP_N      = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dreq",     int'(bus.DREQ), 0);
        chk("rst_fill",     int'(bus.fillLevel), 0);
        chk("rst_db_en",    int'(bus.DB_EN), 0);
        chk("rst_db",       int'(bus.DB), 0);
        chk("rst_eop",      int'(bus.eopSeen), 0);
        chk("rst_underrun", int'(bus.underrun), 0);
        RESET_N = 1'b1;
        tick();
        chk("rst_wrready",  int'(bus.wrReady), 1);

        // Threshold request, single transfer, re-request after IDLE gap
        bus.demandMode = 1'b0;
        for (int i = 0; i < 4; i++)
            push_word(8'hA0 + 8'(i));
        chk("t1_dreq_at_push", int'(bus.DREQ), 0);
        tick();
        chk("t1_dreq_thresh", int'(bus.DREQ), 1);
        bus.DACK = 1'b1;
        tick();
        chk("t1_dreq_serve", int'(bus.DREQ), 1);
        strobe(8'hA0);
        chk("t1_dreq_release", int'(bus.DREQ), 0);
        chk("t1_fill", int'(bus.fillLevel), 3);
        push_word(8'hA4);
        chk("t1_dreq_hold", int'(bus.DREQ), 0);
        bus.DACK = 1'b0;
        tick();
        chk("t1_dreq_idle", int'(bus.DREQ), 0);
        tick();
        chk("t1_dreq_rereq", int'(bus.DREQ), 1);

        // Demand burst of five words
        apply_reset();
        bus.demandMode = 1'b1;
        for (int i = 0; i < 5; i++)
            push_word(8'hA0 + 8'(i));
        wait_dreq("t2_dreq", 1'b1);
        bus.DACK = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            strobe(8'hA0 + 8'(i));
            if (i < 4)
                chk("t2_dreq_mid", int'(bus.DREQ), 1);
        end
        chk("t2_dreq_done", int'(bus.DREQ), 0);
        chk("t2_fill", int'(bus.fillLevel), 0);
        chk("t2_underrun", int'(bus.underrun), 0);
        bus.DACK = 1'b0;
        tick();

        // EOP during the third strobe
        apply_reset();
        bus.demandMode = 1'b1;
        for (int i = 0; i < 8; i++)
            push_word(8'hB0 + 8'(i));
        chk("t3_wrready_full", int'(bus.wrReady), 0);
        chk("t3_fill_full", int'(bus.fillLevel), 8);
        wait_dreq("t3_dreq", 1'b1);
        bus.DACK = 1'b1;
        tick();
        strobe(8'hB0);
        strobe(8'hB1);
        sb.push_back(8'hB2);
        bus.IOR_N = 1'b0;
        bus.EOP_N = 1'b0;
        tick();
        chk("t3_eop_pulse", int'(bus.eopSeen), 1);
        chk("t3_dreq_eop", int'(bus.DREQ), 0);
        tick();
        chk("t3_eop_single", int'(bus.eopSeen), 0);
        bus.IOR_N = 1'b1;
        bus.EOP_N = 1'b1;
        tick();
        chk("t3_fill", int'(bus.fillLevel), 5);
        chk("t3_dreq_after", int'(bus.DREQ), 0);
        bus.DACK = 1'b0;
        tick();

        // Flush request, preemption, then underrun
        apply_reset();
        bus.demandMode = 1'b0;
        bus.flush = 1'b1;
        push_word(8'hC0);
        push_word(8'hC1);
        chk("t4_dreq_flush", int'(bus.DREQ), 1);
        bus.DACK = 1'b1;
        tick();
        bus.DACK = 1'b0;
        tick();
        chk("t4_dreq_preempt", int'(bus.DREQ), 1);
        chk("t4_fill_nopop", int'(bus.fillLevel), 2);
        bus.flush = 1'b0;
        bus.demandMode = 1'b1;
        bus.DACK = 1'b1;
        tick();
        strobe(8'hC0);
        strobe(8'hC1);
        chk("t4_fill_empty", int'(bus.fillLevel), 0);
        chk("t4_dreq_empty", int'(bus.DREQ), 0);
        sb.push_back(8'h00);
        bus.IOR_N = 1'b0;
        tick();
        chk("t4_db_en", int'(bus.DB_EN), 1);
        chk("t4_db_zero", int'(bus.DB), 0);
        tick();
        bus.IOR_N = 1'b1;
        tick();
        chk("t4_underrun", int'(bus.underrun), 1);
        bus.DACK = 1'b0;
        tick();
        tick();
        chk("t4_underrun_sticky", int'(bus.underrun), 1);

        // Full, simultaneous push/pop across pointer wrap, async reset
        apply_reset();
        bus.demandMode = 1'b1;
        for (int i = 0; i < 8; i++)
            push_word(8'h10 + 8'(i));
        chk("t5_wrready_full", int'(bus.wrReady), 0);
        wait_dreq("t5_dreq", 1'b1);
        bus.DACK = 1'b1;
        tick();
        strobe(8'h10);
        chk("t5_fill_7", int'(bus.fillLevel), 7);
        for (int k = 0; k < 20; k++) begin
            sb.push_back(8'h11 + 8'(k));
            bus.IOR_N = 1'b0;
            tick();
            bus.IOR_N   = 1'b1;
            bus.wrData  = 8'h18 + 8'(k);
            bus.wrValid = 1'b1;
            tick();
            bus.wrValid = 1'b0;
            chk("t5_fill_stable", int'(bus.fillLevel), 7);
        end
        chk("t5_dreq_serve", int'(bus.DREQ), 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("t5_async_dreq", int'(bus.DREQ), 0);
        chk("t5_async_fill", int'(bus.fillLevel), 0);
        bus.DACK = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        chk("t5_wrready", int'(bus.wrReady), 1);
        chk("t5_dreq_idle", int'(bus.DREQ), 0);

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
